// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives per-cycle write enables and mux selects.
module multicycle_controller #(
    parameter int unsigned STATE_W = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Instr,
    input  logic               Zero,
    output logic               PC_WEnable,
    output logic               IR_WEnable,
    output logic               GRF_WEnable,
    output logic               DM_WEnable,
    output logic [1:0]         IFUCG_Mode,
    output logic [1:0]         EXT_Mode,
    output logic [3:0]         ALU_Operation,
    output logic [1:0]         DM_Mode,
    output logic [1:0]         MUX_ALUOp2_Sel,
    output logic [1:0]         MUX_RegWAddr_Sel,
    output logic [1:0]         MUX_RegWData_Sel,
    output logic [STATE_W-1:0] State,
    output logic               InstrDone,
    output logic [CNT_W-1:0]   InstrCount
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;

    logic [5:0] opcode, funct;
    logic       r_type, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw;
    logic       is_beq, is_j, is_jal, is_jr, has_wb, in_instr;
    logic       unused_instr;

    assign opcode       = Instr[31:26];
    assign funct        = Instr[5:0];
    assign unused_instr = ^Instr[25:6];

    assign r_type  = (opcode == 6'h00);
    assign is_addu = r_type && (funct == 6'h21);
    assign is_subu = r_type && (funct == 6'h23);
    assign is_jr   = r_type && (funct == 6'h08);
    assign is_ori  = (opcode == 6'h0D);
    assign is_lui  = (opcode == 6'h0F);
    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2B);
    assign is_beq  = (opcode == 6'h04);
    assign is_j    = (opcode == 6'h02);
    assign is_jal  = (opcode == 6'h03);
    assign has_wb  = is_addu | is_subu | is_ori | is_lui;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Any path not explicitly continued falls back to FETCH, which also covers codes 5-7.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: if (has_wb || is_lw || is_sw || is_beq) state_d = StExec;
            StExec: begin
                if (is_lw || is_sw) state_d = StMem;
                else if (has_wb)    state_d = StWb;
            end
            StMem:    if (is_lw) state_d = StWb;
            default:  state_d = StFetch;
        endcase
    end

    assign in_instr = reset && (state_q == StDecode || state_q == StExec ||
                                state_q == StMem || state_q == StWb);

    always_comb begin
        PC_WEnable       = 1'b0;
        IR_WEnable       = 1'b0;
        GRF_WEnable      = 1'b0;
        DM_WEnable       = 1'b0;
        IFUCG_Mode       = 2'd0;
        EXT_Mode         = 2'd0;
        ALU_Operation    = 4'd0;
        DM_Mode          = 2'd0;
        MUX_ALUOp2_Sel   = 2'd0;
        MUX_RegWAddr_Sel = 2'd0;
        MUX_RegWData_Sel = 2'd0;
        InstrDone        = 1'b0;
        if (reset) begin
            case (state_q)
                StFetch: begin
                    IR_WEnable = 1'b1;
                    PC_WEnable = 1'b1;
                end
                StDecode: begin
                    PC_WEnable  = is_j | is_jal | is_jr;
                    GRF_WEnable = is_jal;
                end
                StExec:  PC_WEnable  = is_beq & Zero;
                StMem:   DM_WEnable  = is_sw;
                StWb:    GRF_WEnable = has_wb | is_lw;
                default: ;
            endcase
        end
        // Selects carry their decoded value for the whole instruction after FETCH.
        if (in_instr) begin
            if (is_beq)             IFUCG_Mode = 2'd1;
            else if (is_j | is_jal) IFUCG_Mode = 2'd2;
            else if (is_jr)         IFUCG_Mode = 2'd3;
            if (is_lw | is_sw)      EXT_Mode = 2'd1;
            else if (is_lui)        EXT_Mode = 2'd2;
            if (is_subu | is_beq)   ALU_Operation = 4'd1;
            else if (is_ori)        ALU_Operation = 4'd2;
            if (is_ori | is_lui | is_lw | is_sw) MUX_ALUOp2_Sel = 2'd1;
            if (is_addu | is_subu)  MUX_RegWAddr_Sel = 2'd1;
            else if (is_jal)        MUX_RegWAddr_Sel = 2'd2;
            if (is_lw)              MUX_RegWData_Sel = 2'd1;
            else if (is_jal)        MUX_RegWData_Sel = 2'd2;
            InstrDone = (state_d == StFetch);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (InstrDone) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign State      = STATE_W'(state_q);
    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors are queued
// when an instruction is driven and popped as the FSM steps through its states.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        PC_WEnable, IR_WEnable, GRF_WEnable, DM_WEnable, InstrDone;
    logic [1:0]  IFUCG_Mode, EXT_Mode, DM_Mode, MUX_ALUOp2_Sel, MUX_RegWAddr_Sel;
    logic [1:0]  MUX_RegWData_Sel;
    logic [3:0]  ALU_Operation;
    logic [2:0]  State;
    logic [31:0] InstrCount;

    multicycle_controller #(.STATE_W(3), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .Instr            (Instr),
        .Zero             (Zero),
        .PC_WEnable       (PC_WEnable),
        .IR_WEnable       (IR_WEnable),
        .GRF_WEnable      (GRF_WEnable),
        .DM_WEnable       (DM_WEnable),
        .IFUCG_Mode       (IFUCG_Mode),
        .EXT_Mode         (EXT_Mode),
        .ALU_Operation    (ALU_Operation),
        .DM_Mode          (DM_Mode),
        .MUX_ALUOp2_Sel   (MUX_ALUOp2_Sel),
        .MUX_RegWAddr_Sel (MUX_RegWAddr_Sel),
        .MUX_RegWData_Sel (MUX_RegWData_Sel),
        .State            (State),
        .InstrDone        (InstrDone),
        .InstrCount       (InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pc;
        logic       ir;
        logic       grf;
        logic       dm;
        logic [1:0] ifu;
        logic [1:0] ext;
        logic [3:0] alu;
        logic [1:0] dmm;
        logic [1:0] op2;
        logic [1:0] wa;
        logic [1:0] wd;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t v(input int st, pc, ir, grf, dm, ifu, ext, alu, op2, wa, wd,
                               done);
        exp_t e;
        e.st   = 3'(st);
        e.pc   = 1'(pc);
        e.ir   = 1'(ir);
        e.grf  = 1'(grf);
        e.dm   = 1'(dm);
        e.ifu  = 2'(ifu);
        e.ext  = 2'(ext);
        e.alu  = 4'(alu);
        e.dmm  = 2'd0;
        e.op2  = 2'(op2);
        e.wa   = 2'(wa);
        e.wd   = 2'(wd);
        e.done = 1'(done);
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.st   = State;
        o.pc   = PC_WEnable;
        o.ir   = IR_WEnable;
        o.grf  = GRF_WEnable;
        o.dm   = DM_WEnable;
        o.ifu  = IFUCG_Mode;
        o.ext  = EXT_Mode;
        o.alu  = ALU_Operation;
        o.dmm  = DM_Mode;
        o.op2  = MUX_ALUOp2_Sel;
        o.wa   = MUX_RegWAddr_Sel;
        o.wd   = MUX_RegWData_Sel;
        o.done = InstrDone;
        return o;
    endfunction

    // Pops one expected vector per cycle; the first sample is taken in the current cycle.
    task automatic drain(input string name);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            exp_t e, o;
            #1;
            e = q.pop_front();
            o = observe();
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s cyc%0d observed=%h expected=%h", name, i, o, e);
            end
            if (i != n - 1) @(negedge clk);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] exp);
        #1;
        total++;
        assert (InstrCount === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", name, InstrCount, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        Instr = 32'h0;
        Zero  = 1'b0;
        @(negedge clk);
        q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain("reset");
        chk_cnt("reset_cnt", 0);

        // addu
        reset = 1'b1;
        Instr = 32'h00210821;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(v(4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        drain("addu");
        @(negedge clk);
        chk_cnt("addu_cnt", 1);

        // lw
        Instr = 32'h8c010004;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        q.push_back(v(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        q.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        q.push_back(v(4, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1));
        drain("lw");
        @(negedge clk);
        chk_cnt("lw_cnt", 2);

        // sw
        Instr = 32'hac010004;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        q.push_back(v(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        q.push_back(v(3, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1));
        drain("sw");
        @(negedge clk);
        chk_cnt("sw_cnt", 3);

        // beq taken
        Instr = 32'h10650003;
        Zero  = 1'b1;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        q.push_back(v(2, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        drain("beq_taken");
        @(negedge clk);
        chk_cnt("beq_taken_cnt", 4);

        // beq not taken
        Zero = 1'b0;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        q.push_back(v(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        drain("beq_not_taken");
        @(negedge clk);
        chk_cnt("beq_not_taken_cnt", 5);

        // jal
        Instr = 32'h0c000c22;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 1, 0, 1, 0, 2, 0, 0, 0, 2, 2, 1));
        drain("jal");
        @(negedge clk);
        chk_cnt("jal_cnt", 6);

        // jr
        Instr = 32'h03e00008;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1));
        drain("jr");
        @(negedge clk);
        chk_cnt("jr_cnt", 7);

        // lui interrupted by reset in EXEC
        Instr = 32'h3c027878;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0));
        q.push_back(v(2, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0));
        drain("lui");
        reset = 1'b0;
        q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain("lui_reset");
        chk_cnt("lui_reset_cnt", 0);

        // nop after reset release
        @(negedge clk);
        reset = 1'b1;
        Instr = 32'h00000000;
        q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drain("nop");
        @(negedge clk);
        chk_cnt("nop_cnt", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle MIPS datapath (IR, PC, GRF, ALU, EXT, DM shared across cycles).
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Asserts per-cycle write enables and mux selects, plus branch/jump control for the IFU.
- Decodes the latched IR word; drop-in replacement for the single-cycle Controller's control outputs.

Parameters:
- STATE_W, 3, state register width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  IR output; stable from DECODE until the next FETCH.
- Zero  in  1  ALU equality flag, valid in EXEC.
- PC_WEnable  out  1  PC update strobe.
- IR_WEnable  out  1  IR load strobe.
- GRF_WEnable  out  1  register-file write.
- DM_WEnable  out  1  data-memory write.
- IFUCG_Mode  out  2  next-PC source: 0 PC+4, 1 branch, 2 j-imm, 3 jr-reg.
- EXT_Mode  out  2  extender mode: 0 zero, 1 sign, 2 upper16.
- ALU_Operation  out  4  ALU op: 0 add, 1 sub, 2 or.
- DM_Mode  out  2  memory access width; always 0 (word).
- MUX_ALUOp2_Sel  out  2  ALU operand 2: 0 rt, 1 EXT.
- MUX_RegWAddr_Sel  out  2  GRF write address: 0 rt, 1 rd, 2 $31.
- MUX_RegWData_Sel  out  2  GRF write data: 0 ALU, 1 DM, 2 PC+4.
- State  out  3  current state, for debug.
- InstrDone  out  1  high in the last cycle of each instruction.
- InstrCount  out  CNT_W  retired-instruction counter.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Codes 5-7 are illegal and return to FETCH on the next edge.
- While reset is low:
  - State=FETCH, InstrCount=0.
  - All four write enables and InstrDone forced to 0.
  - Selects = 0.
- The first rising edge after reset releases performs FETCH.
- FETCH (every instruction): IR_WEnable=1, PC_WEnable=1, IFUCG_Mode=0; always goes to DECODE.
- Decode is combinational on Instr, opcode [31:26] and funct [5:0]:

| Instruction | Encoding | Cycle path and actions |
|---|---|---|
| addu | op 0 / funct 21h | D→E→W. ALU 0, Op2 0, WAddr 1, WData 0. |
| subu | op 0 / funct 23h | As addu with ALU 1. |
| ori | 0Dh | D→E→W. EXT 0, Op2 1, ALU 2, WAddr 0. |
| lui | 0Fh | D→E→W. EXT 2, Op2 1, ALU 0, WAddr 0. |
| lw | 23h | D→E→M→W. EXT 1, Op2 1, ALU 0. W: WAddr 0, WData 1. |
| sw | 2Bh | D→E→M. EXT 1, Op2 1, ALU 0. DM_WEnable=1 in MEM only. |
| beq | 04h | D→E. ALU 1, Op2 0. In EXEC: PC_WEnable=Zero, IFUCG_Mode=1. |
| j | 02h | DECODE only. PC_WEnable=1, IFUCG_Mode=2. |
| jal | 03h | DECODE only. PC_WEnable=1, IFUCG_Mode=2, GRF_WEnable=1, WAddr 2, WData 2. PC+4 is the value latched in FETCH. |
| jr | op 0 / funct 08h | DECODE only. PC_WEnable=1, IFUCG_Mode=3. |
| nop (all-zero) and any undefined encoding | — | DECODE only, no writes. |

- Enables are asserted only in the listed state; selects hold their decoded value from DECODE through the final state.
- GRF_WEnable is asserted only in WB, except for jal (DECODE).
- InstrDone=1 in the final state of each path; the next state after it is FETCH.
- InstrCount increments by 1 on each rising edge where InstrDone=1, wrapping modulo 2^CNT_W.
- beq with Zero=0: InstrDone=1 in EXEC with PC_WEnable=0.
- Reset asserted mid-instruction: outputs drop immediately (asynchronous); a partial instruction produces no further writes.
- Instr changes outside FETCH are not expected; the FSM follows current Instr combinationally.

Test Plan:
- Reset release, then Instr=32'h00210821 (addu). Required:
  - State 0,1,2,4,0.
  - GRF_WEnable=1 only in WB, with WAddr 1 and WData 0.
  - InstrCount 0→1.
- Instr=32'h8c010004 (lw). Required:
  - Path 0,1,2,3,4.
  - EXT 1, Op2 1; WData 1 in WB.
  - DM_WEnable never asserted.
- Instr=32'hac010004 (sw). Required:
  - Path 0,1,2,3.
  - DM_WEnable=1 only in MEM; GRF_WEnable always 0.
  - InstrDone in MEM.
- Instr=32'h10650003 (beq). Required:
  - Zero=1: EXEC has PC_WEnable=1, IFUCG_Mode=1.
  - Zero=0: EXEC has PC_WEnable=0.
  - Both cases: 3-cycle path.
- Instr=32'h0c000c22 (jal), then 32'h03e00008 (jr). Required:
  - jal in DECODE: PC_WEnable=1, IFUCG_Mode=2, GRF_WEnable=1, WAddr 2, WData 2.
  - jr in DECODE: IFUCG_Mode=3.
  - Each instruction takes 2 cycles.
- Instr=32'h3c027878 (lui), with reset pulled low during EXEC. Required:
  - All enables 0 immediately; State=0; InstrCount=0.
  - After release, the FSM restarts at FETCH.
  - Instr=32'h00000000 then completes in 2 cycles with no writes.
